nibble_reg_loader: RTL and testbench

//  Multi-channel nibble-serial register loader; successor to the fixed two-channel weight/data SPI loaders.
//  NUM_CH independent REG_W-bit registers are filled LANES bits per clock from a shared input bus.
//  A select field steers each beat to one channel.

---
 rtl/nibble_reg_loader_pkg.sv | 20 ++
 rtl/nibble_reg_loader_if.sv | 32 +++
 rtl/nibble_reg_loader_channel.sv | 78 +++++++
 rtl/nibble_reg_loader.sv | 89 ++++++++
 tb/tb_nibble_reg_loader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/nibble_reg_loader_pkg.sv
// Shared types and elaboration helpers for the nibble-serial register loader.
// The optional readback path is enabled with the LOADER_READBACK_EN macro.
package nibble_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  function automatic int beats_f(input int reg_w, input int lanes);
    return reg_w / lanes;
  endfunction

  // A register must hold a whole number of beats, and there must be at least two channels.
  function automatic bit params_legal(input int reg_w, input int lanes, input int num_ch);
    return (lanes > 0) && (reg_w >= lanes) && ((reg_w % lanes) == 0) && (num_ch >= 2);
  endfunction

endpackage

// File: rtl/nibble_reg_loader_if.sv
// Beat bus between the pin mux (master) and the loader (slave).
// The LOADER_READBACK_EN macro decides whether dout carries readback data.
interface nibble_reg_loader_if
  import nibble_loader_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NUM_CH = 2,
  parameter int REG_W  = 128
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [LANES-1:0]        din;
  logic [SEL_W-1:0]        sel;
  logic                    wr_en;
  logic                    rd_en;
  logic [NUM_CH-1:0]       clr_mask;
  logic [LANES-1:0]        dout;
  logic [NUM_CH*REG_W-1:0] reg_q;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       ovf;
  logic                    busy;

  modport master (
    output din, sel, wr_en, rd_en, clr_mask,
    input  dout, reg_q, full, ovf, busy
  );

  modport slave (
    input  din, sel, wr_en, rd_en, clr_mask,
    output dout, reg_q, full, ovf, busy
  );
endinterface

// File: rtl/nibble_reg_loader_channel.sv
// One loader channel: MSB-first shift register, beat counter, fill-state FSM and sticky ovf.
// With LOADER_READBACK_EN defined, rd rotates the register left by one beat.
module loader_channel
  import nibble_loader_pkg::*;
#(
  parameter int LANES = 4,
  parameter int REG_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic             rd,
  input  logic [LANES-1:0] din,
  output logic [REG_W-1:0] q,
  output logic             full,
  output logic             ovf,
  output logic             loading
);
  localparam int BEATS = beats_f(REG_W, LANES);
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [REG_W-1:0] q_nxt;
  logic             ovf_nxt;
  state_e           state;

  // The beat counter is the state register; the FSM state is a decode of it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    q_nxt   = q;
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (cnt == '0)                      state = ST_IDLE;
    else if (cnt == CNT_W'(BEATS))      state = ST_FULL;
    else                                state = ST_LOADING;

    if (clr) begin
      q_nxt   = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (wr) begin
      if (state == ST_FULL) begin
        ovf_nxt = 1'b1;
      end else begin
        q_nxt   = (q << LANES) | REG_W'(din);
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
`ifdef LOADER_READBACK_EN
    else if (rd) begin
      q_nxt = (q << LANES) | (q >> (REG_W - LANES));
    end
`endif
  end

`ifndef LOADER_READBACK_EN
  logic unused_rd;
  assign unused_rd = rd;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      q   <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  assign full    = (state == ST_FULL);
  assign loading = (state == ST_LOADING);

endmodule

// File: rtl/nibble_reg_loader.sv
// Multi-channel nibble-serial register loader: sel decode, channel array, busy and readback.
// Readback (rd_en rotate and registered dout) exists only when LOADER_READBACK_EN is defined.
module nibble_reg_loader
  import nibble_loader_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NUM_CH = 2,
  parameter int REG_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  nibble_reg_loader_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  if (!params_legal(REG_W, LANES, NUM_CH)) begin : g_param_err
    $error("nibble_reg_loader: REG_W must be a multiple of LANES and NUM_CH >= 2");
  end

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] wr_vec;
  logic [NUM_CH-1:0] rd_vec;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] ovf_vec;
  logic [NUM_CH-1:0] loading_vec;
  logic [REG_W-1:0]  ch_q [NUM_CH];

  // An out-of-range sel matches no channel, so its beat is silently dropped.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (bus.sel == SEL_W'(k));
    end
  end

  assign wr_vec = sel_hit & {NUM_CH{bus.wr_en}};
  assign rd_vec = sel_hit & {NUM_CH{bus.rd_en}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    loader_channel #(
      .LANES (LANES),
      .REG_W (REG_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.clr_mask[k]),
      .wr      (wr_vec[k]),
      .rd      (rd_vec[k]),
      .din     (bus.din),
      .q       (ch_q[k]),
      .full    (full_vec[k]),
      .ovf     (ovf_vec[k]),
      .loading (loading_vec[k])
    );
    assign bus.reg_q[k*REG_W +: REG_W] = ch_q[k];
  end

  assign bus.full = full_vec;
  assign bus.ovf  = ovf_vec;
  assign bus.busy = |loading_vec;

`ifdef LOADER_READBACK_EN
  logic [LANES-1:0] rd_nib;
  logic             rd_go;
  logic [LANES-1:0] dout_q;

  // dout captures the top beat before the rotate, mirroring what the channel shifts out.
  always_comb begin
    rd_nib = '0;
    rd_go  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_hit[k]) begin
        rd_nib = ch_q[k][REG_W-1 -: LANES];
        rd_go  = bus.rd_en && !bus.wr_en && !bus.clr_mask[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_go) dout_q <= rd_nib;
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = '0;
`endif

endmodule

// File: tb/tb_nibble_reg_loader.sv
// Self-checking bench for nibble_reg_loader (LANES=4, REG_W=32, NUM_CH=2).
// Readback expectations follow whether LOADER_READBACK_EN is defined for the build.
module tb_nibble_reg_loader;
  localparam int LANES  = 4;
  localparam int NUM_CH = 2;
  localparam int REG_W  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_reg_loader_if #(.LANES(LANES), .NUM_CH(NUM_CH), .REG_W(REG_W)) bus ();

  nibble_reg_loader #(.LANES(LANES), .NUM_CH(NUM_CH), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [1:0] clr;
    logic       wr;
    logic       rd;
    logic       sel;
    logic [3:0] din;
  } stim_t;

  typedef struct {
    logic [31:0] ch0;
    logic [31:0] ch1;
    logic [1:0]  full;
    logic [1:0]  ovf;
    logic        busy;
    logic [3:0]  dout;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] clr, input logic wr, input logic rd,
                              input logic sel, input logic [3:0] din,
                              input logic [31:0] ch0, input logic [31:0] ch1,
                              input logic [1:0] full, input logic [1:0] ovf,
                              input logic busy, input logic [3:0] dout);
    vec_t v;
    v.s = '{rst: r, clr: clr, wr: wr, rd: rd, sel: sel, din: din};
    v.e = '{ch0: ch0, ch1: ch1, full: full, ovf: ovf, busy: busy, dout: dout};
    return v;
  endfunction

  // Pops the oldest expectation and compares it against the DUT outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".ch0"},  bus.reg_q[31:0],  e.ch0);
      check({tag, ".ch1"},  bus.reg_q[63:32], e.ch1);
      check({tag, ".full"}, 32'(bus.full),    32'(e.full));
      check({tag, ".ovf"},  32'(bus.ovf),     32'(e.ovf));
      check({tag, ".busy"}, 32'(bus.busy),    32'(e.busy));
      check({tag, ".dout"}, 32'(bus.dout),    32'(e.dout));
    end
  endtask

  task automatic drive(input stim_t s, input exp_t e, input string tag);
    @(negedge clk);
    rst          = s.rst;
    bus.clr_mask = s.clr;
    bus.wr_en    = s.wr;
    bus.rd_en    = s.rd;
    bus.sel      = s.sel;
    bus.din      = s.din;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    logic [31:0] ch0_exp;
    logic [3:0]  dout_exp;
    stim_t       s;
    exp_t        e;

    rst          = 1'b1;
    bus.clr_mask = '0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.sel      = '0;
    bus.din      = '0;

    //            rst clr   wr rd sel din    ch0           ch1           full   ovf    busy dout
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 4'h0, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));
    tbl.push_back(mk(1, 2'b00, 1, 0, 0, 4'h9, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 4'h0, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));
    // Fill channel 0 MSB-first with beats 1..8.
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h1, 32'h1,        32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h2, 32'h12,       32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h3, 32'h123,      32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h4, 32'h1234,     32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h5, 32'h12345,    32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h6, 32'h123456,   32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h7, 32'h1234567,  32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h8, 32'h12345678, 32'h0,        2'b01, 2'b00, 0, 4'h0));
    // Write into a full channel is dropped and flags overflow.
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'hF, 32'h12345678, 32'h0,        2'b01, 2'b01, 0, 4'h0));
    // Clear ch0 while writing ch1 in the same cycle.
    tbl.push_back(mk(0, 2'b01, 1, 0, 1, 4'hA, 32'h0,        32'hA,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 4'h0, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));
    // Interleaved beats, then reset mid-load beats a concurrent write.
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h1, 32'h1,        32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 4'h2, 32'h1,        32'h2,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h3, 32'h13,       32'h2,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(1, 2'b00, 1, 0, 1, 4'h4, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));
    // Clear on the selected channel wins over its own write.
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 4'h5, 32'h5,        32'h0,        2'b00, 2'b00, 1, 4'h0));
    tbl.push_back(mk(0, 2'b01, 1, 0, 0, 4'h6, 32'h0,        32'h0,        2'b00, 2'b00, 0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reload ch0 from reset, then read it back a full register's worth of beats.
    s = '{rst: 1'b1, clr: 2'b00, wr: 1'b0, rd: 1'b0, sel: 1'b0, din: 4'h0};
    e = '{ch0: 32'h0, ch1: 32'h0, full: 2'b00, ovf: 2'b00, busy: 1'b0, dout: 4'h0};
    drive(s, e, "rb_rst");
    ch0_exp = 32'h0;
    for (int i = 0; i < 8; i++) begin
      s = '{rst: 1'b0, clr: 2'b00, wr: 1'b1, rd: 1'b0, sel: 1'b0, din: 4'(i + 1)};
      ch0_exp = {ch0_exp[27:0], 4'(i + 1)};
      e = '{ch0: ch0_exp, ch1: 32'h0, full: (i == 7) ? 2'b01 : 2'b00, ovf: 2'b00,
            busy: (i != 7), dout: 4'h0};
      drive(s, e, $sformatf("rb_load%0d", i));
    end

    dout_exp = 4'h0;
    for (int i = 0; i < 8; i++) begin
      s = '{rst: 1'b0, clr: 2'b00, wr: 1'b0, rd: 1'b1, sel: 1'b0, din: 4'h0};
`ifdef LOADER_READBACK_EN
      dout_exp = 4'(i + 1);
      ch0_exp  = {ch0_exp[27:0], ch0_exp[31:28]};
`endif
      e = '{ch0: ch0_exp, ch1: 32'h0, full: 2'b01, ovf: 2'b00, busy: 1'b0, dout: dout_exp};
      drive(s, e, $sformatf("rb_read%0d", i));
    end
    check("rb_restored", bus.reg_q[31:0], 32'h12345678);

    // Write beats read on a full channel: no rotate, dout holds, overflow is flagged.
    s = '{rst: 1'b0, clr: 2'b00, wr: 1'b1, rd: 1'b1, sel: 1'b0, din: 4'hF};
    e = '{ch0: 32'h12345678, ch1: 32'h0, full: 2'b01, ovf: 2'b01, busy: 1'b0, dout: dout_exp};
    drive(s, e, "rb_wr_over_rd");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
